// File: rtl/assert_proposition_window_if.sv
// assert_proposition_window_if: proposition inputs and fire reporting outputs of the window checker
interface assert_proposition_window_if #(
  parameter int width = 1,
  parameter int cnt_width = 8
);
  logic enable;
  logic clear;
  logic [width-1:0] test_expr;
  logic [width-1:0] fire;
  logic [width-1:0] fire_sticky;
  logic [cnt_width-1:0] fire_count;
  modport master(output enable, clear, test_expr, input fire, fire_sticky, fire_count);
  modport slave(input enable, clear, test_expr, output fire, fire_sticky, fire_count);
endinterface

// File: rtl/assert_proposition_window.sv
// assert_proposition_window: multi-channel clocked proposition checker with per-channel glitch tolerance
`ifndef OVL_FATAL
`define OVL_FATAL 0
`endif
`ifndef OVL_ERROR
`define OVL_ERROR 1
`endif
`ifndef OVL_SEVERITY_DEFAULT
`define OVL_SEVERITY_DEFAULT `OVL_ERROR
`endif
`ifndef OVL_ASSERT
`define OVL_ASSERT 0
`endif
`ifndef OVL_ASSUME
`define OVL_ASSUME 1
`endif
`ifndef OVL_IGNORE
`define OVL_IGNORE 2
`endif
module assert_proposition_window #(
  parameter int severity_level = `OVL_SEVERITY_DEFAULT,
  parameter int property_type = `OVL_ASSERT,
  parameter msg = "VIOLATION",
  parameter int width = 1,
  parameter int tolerance = 0,
  parameter int cnt_width = 8
) (
  input logic clk,
  input logic reset_n,
  assert_proposition_window_if.slave bus
);
  typedef enum logic [1:0] {OK, PEND, FAILED} state_t;
  localparam bit ON = property_type != `OVL_IGNORE;
  localparam logic [7:0] TOL = 8'(tolerance);
  localparam logic [39:0] MAX = (40'd1 << cnt_width) - 40'd1;
  logic [width-1:0] ev, fire_q, sticky_q;
  logic [cnt_width-1:0] cnt_q, cnt_n;
  logic [39:0] sum;
  for (genvar g = 0; g < width; g++) begin : ch
    state_t st, st_n;
    logic [7:0] rn, rn_n;
    logic e;
    // an X/Z sample falls through to the false branches
    always_comb begin
      st_n = st;
      rn_n = rn;
      e = 1'b0;
      if (!bus.enable || bus.test_expr[g]) begin
        st_n = OK;
        rn_n = '0;
      end else if (st == OK && TOL != 8'd0) begin
        st_n = PEND;
        rn_n = 8'd1;
      end else if (st != FAILED && (st == OK || rn == TOL)) begin
        st_n = FAILED;
        e = 1'b1;
      end else if (st == PEND) rn_n = rn + 8'd1;
    end
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        st <= OK;
        rn <= '0;
      end else begin
        st <= st_n;
        rn <= rn_n;
      end
    end
    assign ev[g] = e;
  end
  assign sum = 40'(bus.clear ? '0 : cnt_q) + 40'($countones(ev));
  assign cnt_n = sum > MAX ? MAX[cnt_width-1:0] : sum[cnt_width-1:0];
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fire_q <= '0;
      sticky_q <= '0;
      cnt_q <= '0;
    end else begin
      fire_q <= ev;
      sticky_q <= (bus.clear ? '0 : sticky_q) | ev;
      cnt_q <= cnt_n;
    end
  end
  assign bus.fire = ON ? fire_q : '0;
  assign bus.fire_sticky = ON ? sticky_q : '0;
  assign bus.fire_count = ON ? cnt_q : '0;
`ifdef OVL_ASSERT_ON
  task automatic ovl_error_t(input string s);
    $display("OVL_ERROR : ASSERT_PROPOSITION_WINDOW : %s : severity %0d : time %0t : %m", s, severity_level, $time);
    if (severity_level == `OVL_FATAL) $finish;
  endtask
  always @(posedge clk)
    if (ON && reset_n && bus.enable)
      for (int c = 0; c < width; c++) begin
`ifndef OVL_XCHECK_OFF
        if ($isunknown(bus.test_expr[c])) ovl_error_t("test_expr contains X or Z");
`endif
        if (ev[c]) ovl_error_t(msg);
      end
  initial
    if (property_type != `OVL_ASSERT && property_type != `OVL_ASSUME && property_type != `OVL_IGNORE)
      ovl_error_t("");
`else
  logic unused_cfg;
  assign unused_cfg = ^{severity_level[0], msg[0]};
`endif
`ifdef OVL_INIT_MSG
  task automatic ovl_init_msg_t;
    $display("OVL_NOTE: ASSERT_PROPOSITION_WINDOW initialized @ %m, severity %0d, type %0d", severity_level, property_type);
  endtask
  initial ovl_init_msg_t;
`endif
endmodule

// File: tb/tb_assert_proposition_window.sv
// tb_assert_proposition_window: four checker configurations driven together and scored against a false-run model
module tb_assert_proposition_window;
  logic clk = 1'b0;
  logic rn, en, clr;
  logic [7:0] tx [4];
  int n_vec = 0, n_err = 0;
  int W [4] = '{4, 4, 8, 4};
  int T [4] = '{0, 3, 0, 2};
  int C [4] = '{8, 8, 2, 8};
  int zr [4][8];
  logic [7:0] mf [4], ms [4];
  int mc [4];
  always #5 clk = ~clk;
  assert_proposition_window_if #(.width(4), .cnt_width(8)) b0 ();
  assert_proposition_window_if #(.width(4), .cnt_width(8)) b1 ();
  assert_proposition_window_if #(.width(8), .cnt_width(2)) b2 ();
  assert_proposition_window_if #(.width(4), .cnt_width(8)) b3 ();
  assign b0.enable = en;
  assign b1.enable = en;
  assign b2.enable = en;
  assign b3.enable = en;
  assign b0.clear = clr;
  assign b1.clear = clr;
  assign b2.clear = clr;
  assign b3.clear = clr;
  assign b0.test_expr = tx[0][3:0];
  assign b1.test_expr = tx[1][3:0];
  assign b2.test_expr = tx[2];
  assign b3.test_expr = tx[3][3:0];
  assert_proposition_window #(.width(4), .tolerance(0), .cnt_width(8)) d0 (.clk(clk), .reset_n(rn), .bus(b0));
  assert_proposition_window #(.width(4), .tolerance(3), .cnt_width(8)) d1 (.clk(clk), .reset_n(rn), .bus(b1));
  assert_proposition_window #(.width(8), .tolerance(0), .cnt_width(2)) d2 (.clk(clk), .reset_n(rn), .bus(b2));
  assert_proposition_window #(.width(4), .tolerance(2), .cnt_width(8)) d3 (.clk(clk), .reset_n(rn), .bus(b3));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  // a channel fires exactly when its run of enabled false samples reaches tolerance+1
  task automatic model;
    for (int d = 0; d < 4; d++) begin
      logic [7:0] f;
      int mx;
      f = '0;
      mx = (1 << C[d]) - 1;
      if (!rn) begin
        for (int c = 0; c < 8; c++) zr[d][c] = 0;
        ms[d] = '0;
        mc[d] = 0;
      end else begin
        for (int c = 0; c < W[d]; c++)
          if (!en || tx[d][c]) zr[d][c] = 0;
          else begin
            zr[d][c]++;
            if (zr[d][c] == T[d] + 1) f[c] = 1'b1;
          end
        ms[d] = (clr ? 8'h00 : ms[d]) | f;
        mc[d] = (clr ? 0 : mc[d]) + $countones(f);
        if (mc[d] > mx) mc[d] = mx;
      end
      mf[d] = f;
    end
  endtask
  task automatic step;
    @(posedge clk);
    model;
    #1;
    chk("d0.fire", 64'(b0.fire), 64'(mf[0]));
    chk("d0.sticky", 64'(b0.fire_sticky), 64'(ms[0]));
    chk("d0.count", 64'(b0.fire_count), 64'(mc[0]));
    chk("d1.fire", 64'(b1.fire), 64'(mf[1]));
    chk("d1.sticky", 64'(b1.fire_sticky), 64'(ms[1]));
    chk("d1.count", 64'(b1.fire_count), 64'(mc[1]));
    chk("d2.fire", 64'(b2.fire), 64'(mf[2]));
    chk("d2.sticky", 64'(b2.fire_sticky), 64'(ms[2]));
    chk("d2.count", 64'(b2.fire_count), 64'(mc[2]));
    chk("d3.fire", 64'(b3.fire), 64'(mf[3]));
    chk("d3.sticky", 64'(b3.fire_sticky), 64'(ms[3]));
    chk("d3.count", 64'(b3.fire_count), 64'(mc[3]));
  endtask
  initial begin
    rn = 1'b0;
    en = 1'b1;
    clr = 1'b0;
    for (int d = 0; d < 4; d++) tx[d] = 8'hFF;
    step;
    step;
    chk("reset.count", 64'(b0.fire_count), 64'd0);
    chk("reset.sticky", 64'(b2.fire_sticky), 64'd0);
    rn = 1'b1;
    repeat (3) step;
    tx[0] = 8'hFD;
    step;
    chk("tp1.fire", 64'(b0.fire), 64'h2);
    step;
    chk("tp1.fire_after", 64'(b0.fire), 64'h0);
    chk("tp1.sticky", 64'(b0.fire_sticky), 64'h2);
    chk("tp1.count", 64'(b0.fire_count), 64'd1);
    tx[0] = 8'hFF;
    tx[1] = 8'hFE;
    repeat (3) step;
    tx[1] = 8'hFF;
    step;
    chk("tp2.glitch", 64'(b1.fire_sticky), 64'h0);
    tx[1] = 8'hFE;
    for (int i = 1; i <= 9; i++) begin
      step;
      chk("tp2.pulse", 64'(b1.fire[0]), 64'(i == 4));
    end
    chk("tp2.count", 64'(b1.fire_count), 64'd1);
    tx[1] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tx[2] = 8'h00;
      step;
      chk("tp3.fire", 64'(b2.fire), 64'hFF);
      tx[2] = 8'hFF;
      step;
    end
    chk("tp3.count", 64'(b2.fire_count), 64'd3);
    chk("tp3.sticky", 64'(b2.fire_sticky), 64'hFF);
    tx[0] = 8'hF0;
    step;
    tx[0] = 8'hFF;
    step;
    chk("tp4.prior", 64'(b0.fire_count), 64'd5);
    tx[0] = 8'hFB;
    clr = 1'b1;
    step;
    clr = 1'b0;
    chk("tp4.count", 64'(b0.fire_count), 64'd1);
    chk("tp4.sticky", 64'(b0.fire_sticky), 64'h4);
    tx[0] = 8'hFF;
    en = 1'b0;
    tx[3] = 8'h00;
    for (int i = 0; i < 20; i++) begin
      step;
      chk("tp5.off", 64'(b3.fire), 64'h0);
    end
    chk("tp5.kept", 64'(b0.fire_count), 64'd1);
    en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step;
      chk("tp5.on", 64'(b3.fire), i == 3 ? 64'hF : 64'h0);
    end
    tx[3] = 8'hFF;
    tx[1] = 8'hFE;
    repeat (2) step;
    rn = 1'b0;
    step;
    chk("tp6.fire", 64'(b1.fire), 64'h0);
    chk("tp6.sticky", 64'(b1.fire_sticky), 64'h0);
    chk("tp6.count", 64'(b1.fire_count), 64'd0);
    rn = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step;
      chk("tp6.pulse", 64'(b1.fire[0]), 64'(i == 4));
    end
    tx[1] = 8'hFF;
    for (int i = 0; i < 400; i++) begin
      rn = ($urandom % 64) != 0;
      en = ($urandom % 16) != 0;
      clr = ($urandom % 16) == 0;
      for (int d = 0; d < 4; d++) tx[d] = tx[d] ^ 8'($urandom & $urandom);
      step;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/assert_proposition_window.md
# assert_proposition_window

- Clocked, multi-channel successor to the unclocked proposition checker in the OVL library.
- Each of `width` channels carries a proposition that must hold on every sampled clock edge. A channel fires only after its proposition has been false for more than `tolerance` consecutive samples, and it fires once per failure episode.
- The block keeps sticky per-channel fire flags and a saturating aggregate fire counter.
- It sits with the other OVL checkers and reports through the standard OVL error task. It is used wherever a bundle of invariants must be checked with glitch filtering.

## Interface
- `severity_level`, default `` `OVL_SEVERITY_DEFAULT``: passed to the OVL error task; `OVL_FATAL` ends simulation after the report.
- `property_type`, default `` `OVL_ASSERT``: `OVL_ASSERT` or `OVL_ASSUME` enables checking; `OVL_IGNORE` forces all outputs to 0.
- `msg`, default `"VIOLATION"`: message text for the error task.
- `width`, default 1: number of channels, 1..64.
- `tolerance`, default 0: consecutive false samples allowed per channel before firing, 0..255.
- `cnt_width`, default 8: width of `fire_count`, 1..32.
- `clk`, input, 1: rising-edge clock.
- `reset_n`, input, 1: reset, synchronous and active-low. Driven from `` `OVL_RESET_SIGNAL`` at instantiation.
- `enable`, input, 1: checking enable.
- `clear`, input, 1: synchronous clear of `fire_sticky` and `fire_count`.
- `test_expr`, input, `width`: propositions; bit i must be 1.
- `fire`, output, `width`: one-cycle pulse per channel fire event.
- `fire_sticky`, output, `width`: set by `fire`, held until `clear` or reset.
- `fire_count`, output, `cnt_width`: saturating total of channel fire events.

## Operation
- Per-channel FSM with states OK, PEND and FAILED, plus a run counter `run` that saturates at `tolerance`.
- In OK:
  - Sample 1: stay in OK.
  - Sample 0 with `tolerance`==0: fire and go to FAILED.
  - Sample 0 with `tolerance`>0: `run`←1, go to PEND.
- In PEND:
  - Sample 1: `run`←0, go to OK.
  - Sample 0 with `run`==`tolerance`: fire and go to FAILED.
  - Otherwise: `run`←`run`+1.
- In FAILED:
  - Sample 1: `run`←0, go to OK (re-armed).
  - Sample 0: stay in FAILED with no further fire.
- A fire event on channel i does all of the following on that edge:
  - `fire[i]`←1 for one cycle.
  - `fire_sticky[i]`←1.
  - `ovl_error_t(msg)` is called once, under `` `OVL_ASSERT_ON``.
- `fire_count` adds the popcount of the `fire` events taken on the same edge, saturating at 2^`cnt_width`−1 with no wrap.
- `enable`=0:
  - All FSMs are forced to OK, `run`←0 and `fire`←0.
  - `fire_sticky` and `fire_count` are retained.
  - `test_expr` is ignored.
- `clear`=1 on an edge:
  - `fire_sticky` and `fire_count` are cleared first, then that edge's fire events are applied. So `fire_sticky` equals the new `fire`, and `fire_count` equals its popcount.
  - FSM state is unaffected.
- X-check: with `` `OVL_XCHECK_OFF`` undefined, an X or Z sample on an enabled channel reports `"test_expr contains X or Z"` via `ovl_error_t` and is treated as 0.
- `property_type`=`OVL_IGNORE`: all outputs are constantly 0 and no reports are made. Any other invalid value calls `ovl_error_t("")` at time 0.
- `` `OVL_INIT_MSG`` calls `ovl_init_msg_t` at time 0.

## Timing
- All state is registered on the rising edge of `clk`. There are no combinational paths from input to output.
- Reset (`reset_n`=0 at an edge):
  - FSMs go to OK and `run`←0.
  - `fire`=0, `fire_sticky`=0 and `fire_count`=0 after that edge.
  - Reset has priority over `enable` and `clear`.
  - Reset in the middle of a PEND or FAILED episode discards it; counting restarts from the first sample after release.
- Latency:
  - With channel i false from edge k onward, `fire[i]` goes high after edge k+`tolerance` and is high for exactly one cycle.
  - `fire_sticky` and `fire_count` update on the same edge as `fire`.
- A single true sample anywhere in the false run restarts the count.
- Channels are fully independent. Simultaneous fires on all channels are legal.

## Test plan
- `width`=4, `tolerance`=0, `test_expr` drops to 4'b1101 at edge 10 and stays there:
  - `fire`=4'b0010 after edge 10 only.
  - `fire_sticky`=4'b0010.
  - `fire_count`=1.
- `tolerance`=3, bit 0 false at edges 5–7 then true at 8: no fire. False again at edges 12–20: single `fire[0]` pulse after edge 15, and `fire_count`=1.
- `width`=8, `cnt_width`=2, all bits false for 1 cycle then true, repeated 3 times:
  - `fire`=8'hFF on each episode.
  - `fire_count` saturates at 3.
  - `fire_sticky`=8'hFF.
- `clear`=1 on the same edge as a `fire[2]` event, with a prior `fire_count` of 5: `fire_count`=1 and `fire_sticky`=4'b0100.
- `enable`=0 with `test_expr`=0 for 20 cycles: `fire`=0 throughout and sticky/count unchanged. Raise `enable` with `tolerance`=2: fire occurs 2 edges after the first enabled sample edge.
- `reset_n`=0 mid-PEND (`run`=2, `tolerance`=3) with the input staying false: all outputs are 0 after the reset edge. After release, fire occurs on the 4th false sample edge.
